// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: producer handshake and uart_tx strobe bundle for uart_tx_queue
//  master: producer/consumer side; slave: the queue itself
//  in_valid/in_data/in_ready: byte producer handshake
//  tx_valid/tx_data: one-cycle strobe and byte for uart_tx
//  busy: queue holds data or is pacing a frame
interface uart_tx_queue_if #(parameter int DATA_BITS = 8);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 busy;
  modport master (output in_valid, in_data, input in_ready, tx_valid, tx_data, busy);
  modport slave  (input in_valid, in_data, output in_ready, tx_valid, tx_data, busy);
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO that paces one-cycle tx_valid strobes to uart_tx a frame time apart
//  clk, rst : system clock, synchronous active-high reset
//  bus      : uart_tx_queue_if.slave (in_valid/in_data/in_ready, tx_valid/tx_data, busy)
//  Optional UART_TXQ_STATUS_EN adds level (current count), ovf (sticky overflow), ovf_clr.
module uart_tx_queue #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUDRATE   = 115200,
  parameter int CLK_FREQ   = 75_000_000,
  parameter int DEPTH      = 16,
  parameter int GUARD_CLKS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef UART_TXQ_STATUS_EN
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf,
  input  logic                      ovf_clr,
`endif
  uart_tx_queue_if.slave            bus
);
  localparam int FULLBAUD   = CLK_FREQ / BAUDRATE;
  localparam int FRAME_CLKS = FULLBAUD * (1 + DATA_BITS + STOP_BITS) + GUARD_CLKS;
  localparam int AW         = $clog2(DEPTH);
  localparam int HW         = $clog2(FRAME_CLKS + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t               r_state, w_next;
  logic [HW-1:0]        r_holdoff;
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_tx_valid;
  logic [DATA_BITS-1:0] r_tx_data;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic                 w_ready, w_wr, w_pop;
  // Full blocks writes even when a pop is happening, so there is no pass-through path.
  always_comb begin
    w_ready = r_count != (AW+1)'(DEPTH);
    w_wr    = bus.in_valid && w_ready;
    w_pop   = r_state == ISSUE;
    w_next  = r_state == IDLE  ? (r_count != '0 ? ISSUE : IDLE) :
              r_state == ISSUE ? HOLD :
              r_holdoff != '0  ? HOLD : (r_count != '0 ? ISSUE : IDLE);
  end
  always_ff @(posedge clk) if (w_wr) r_mem[r_wr_ptr] <= bus.in_data;
  // Reset lands in HOLD with a full frame of holdoff: uart_tx has no reset and may still be sending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HOLD;
      r_holdoff  <= HW'(FRAME_CLKS - 1);
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_holdoff  <= w_pop ? HW'(FRAME_CLKS - 1) : (r_holdoff != '0 ? r_holdoff - 1'b1 : r_holdoff);
      r_wr_ptr   <= r_wr_ptr + AW'(w_wr);
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      r_count    <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_tx_valid <= w_pop;
      r_tx_data  <= w_pop ? r_mem[r_rd_ptr] : r_tx_data;
    end
  end
  assign bus.in_ready = w_ready;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign bus.busy     = r_count != '0 || r_state != IDLE;
`ifdef UART_TXQ_STATUS_EN
  logic r_ovf;
  // Overflow set takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else r_ovf <= (bus.in_valid && !w_ready) ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);
  end
  assign level = r_count;
  assign ovf   = r_ovf;
`endif
endmodule
